// File: rtl/cw_link_master.sv
// ---------------------------------------------------------------------------
// cw_link_master
//
// Bridges the 16-bit core-side wishbone bus (single beats and 4/8-beat
// bursts) onto the CW pin bus towards the external bridge. Runs in the
// cw_clk domain. Every pin-facing and bus-facing output is a flop. The
// incoming pad signals (cw_ack, cw_err, cw_io_i) are registered once before
// any decision is made on them. A per-beat ack timeout guarantees that a
// dead bridge ends the cycle with wb_err instead of hanging the core.
//
// Pin-bus framing per transaction:
//   HDR   : {we, burst[1:0], sel[1:0], 3'b000, adr[23:16]}
//           burst = 00 single, 01 four beats, 10 eight beats
//   ADR   : adr[15:0]
//   write : (WDAT -> WWAIT) per beat, data held on cw_io_o while waiting
//   read  : TURN (pads released, cw_dir=1), then RWAIT collecting beats
//   END   : one idle cycle with cw_req=0 before any new header
//
// Parameters
//   WB_ADDR_W  wishbone word-address width (17..24); upper header address
//              bits beyond this width are sent as zero
//   TIMEOUT    cycles waited for cw_ack/cw_err per beat before wb_err
//
// Ports
//   i_clk       in   cw_clk domain clock
//   i_rst       in   synchronous, active-high reset
//   wb_cyc      in   bus cycle
//   wb_stb      in   beat strobe
//   wb_we       in   1 = write
//   wb_adr      in   word address
//   wb_sel      in   byte selects
//   wb_o_dat    in   write data from the master
//   wb_i_dat    out  read data to the master
//   wb_ack      out  beat acknowledge, 1-cycle pulse
//   wb_err      out  error/timeout, 1-cycle pulse, ends the cycle
//   wb_4_burst  in   4-beat burst request, sampled at cycle start
//   wb_8_burst  in   8-beat burst request, wins over wb_4_burst
//   cw_io_i     in   pad input data
//   cw_io_o     out  pad output data
//   cw_req      out  transaction active
//   cw_dir      out  1 = pads released for the bridge to drive read data
//   cw_ack      in   bridge beat acknowledge
//   cw_err      in   bridge error
// ---------------------------------------------------------------------------
module cw_link_master #(
    parameter int WB_ADDR_W = 24,
    parameter int TIMEOUT   = 1023
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 wb_cyc,
    input  logic                 wb_stb,
    input  logic                 wb_we,
    input  logic [WB_ADDR_W-1:0] wb_adr,
    input  logic [1:0]           wb_sel,
    input  logic [15:0]          wb_o_dat,
    output logic [15:0]          wb_i_dat,
    output logic                 wb_ack,
    output logic                 wb_err,
    input  logic                 wb_4_burst,
    input  logic                 wb_8_burst,
    input  logic [15:0]          cw_io_i,
    output logic [15:0]          cw_io_o,
    output logic                 cw_req,
    output logic                 cw_dir,
    input  logic                 cw_ack,
    input  logic                 cw_err
);

    localparam int TW = $clog2(TIMEOUT + 1);
    // The counter reads TIMEOUT-1 on the TIMEOUT-th waiting cycle; flagging
    // the error there makes the wb_err flop fire exactly TIMEOUT cycles
    // after the wait state was entered.
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_ADR,
        S_WDAT,
        S_WWAIT,
        S_TURN,
        S_RWAIT,
        S_END
    } state_t;

    // -----------------------------------------------------------------------
    // State and registers
    // -----------------------------------------------------------------------
    state_t         state_q, state_d;

    // Pad inputs, registered once before use.
    logic           ack_r_q;
    logic           err_r_q;
    logic [15:0]    dat_r_q;

    // Transaction context latched in IDLE.
    logic           we_q, we_d;
    logic [1:0]     sel_q, sel_d;
    logic [23:0]    adr_q, adr_d;
    logic [15:0]    wdat_q, wdat_d;
    logic [1:0]     bcode_q, bcode_d;
    logic [3:0]     beats_q, beats_d;

    // Beat progress and per-beat timeout.
    logic [3:0]     beat_q, beat_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    // Write burst: beat acked, waiting for the master to present the next word.
    logic           pend_q, pend_d;

    // Output flops.
    logic [15:0]    cw_io_q, cw_io_d;
    logic           cw_req_q, cw_req_d;
    logic           cw_dir_q, cw_dir_d;
    logic           wb_ack_q, wb_ack_d;
    logic           wb_err_q, wb_err_d;
    logic [15:0]    wb_i_dat_q, wb_i_dat_d;

    logic [23:0]    adr_ext;
    logic           last_beat;

    // Zero-extend the word address to the 24-bit header/address field.
    always_comb begin
        adr_ext                 = '0;
        adr_ext[WB_ADDR_W-1:0]  = wb_adr;
    end

    assign last_beat = ((beat_q + 4'd1) == beats_q);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every variable assigned here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        sel_d      = sel_q;
        adr_d      = adr_q;
        wdat_d     = wdat_q;
        bcode_d    = bcode_q;
        beats_d    = beats_q;
        beat_d     = beat_q;
        pend_d     = pend_q;
        tmo_d      = '0;
        wb_ack_d   = 1'b0;
        wb_err_d   = 1'b0;
        wb_i_dat_d = wb_i_dat_q;

        unique case (state_q)
            S_IDLE: begin
                beat_d = 4'd0;
                pend_d = 1'b0;
                if (wb_cyc && wb_stb) begin
                    we_d   = wb_we;
                    sel_d  = wb_sel;
                    adr_d  = adr_ext;
                    wdat_d = wb_o_dat;
                    if (wb_8_burst) begin
                        bcode_d = 2'b10;
                        beats_d = 4'd8;
                    end else if (wb_4_burst) begin
                        bcode_d = 2'b01;
                        beats_d = 4'd4;
                    end else begin
                        bcode_d = 2'b00;
                        beats_d = 4'd1;
                    end
                    state_d = S_HDR;
                end
            end

            S_HDR: begin
                state_d = wb_cyc ? S_ADR : S_END;
            end

            S_ADR: begin
                if (!wb_cyc) begin
                    state_d = S_END;
                end else begin
                    state_d = we_q ? S_WDAT : S_TURN;
                end
            end

            S_WDAT: begin
                state_d = wb_cyc ? S_WWAIT : S_END;
            end

            S_TURN: begin
                state_d = wb_cyc ? S_RWAIT : S_END;
            end

            S_WWAIT: begin
                if (!wb_cyc) begin
                    // Master abandoned the cycle: no ack, no err.
                    state_d = S_END;
                end else if (err_r_q) begin
                    wb_err_d = 1'b1;
                    state_d  = S_END;
                end else if (pend_q) begin
                    // The master still shows the old word while wb_ack is
                    // high; take the next word on the first strobe after it.
                    if (wb_stb && !wb_ack_q) begin
                        wdat_d  = wb_o_dat;
                        pend_d  = 1'b0;
                        state_d = S_WDAT;
                    end
                end else if (ack_r_q) begin
                    wb_ack_d = 1'b1;
                    beat_d   = beat_q + 4'd1;
                    if (last_beat) begin
                        state_d = S_END;
                    end else begin
                        pend_d = 1'b1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    wb_err_d = 1'b1;
                    state_d  = S_END;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            S_RWAIT: begin
                // Returned data is acked even with wb_stb low.
                if (!wb_cyc) begin
                    state_d = S_END;
                end else if (err_r_q) begin
                    wb_err_d = 1'b1;
                    state_d  = S_END;
                end else if (ack_r_q) begin
                    wb_ack_d   = 1'b1;
                    wb_i_dat_d = dat_r_q;
                    beat_d     = beat_q + 4'd1;
                    if (last_beat) begin
                        state_d = S_END;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    wb_err_d = 1'b1;
                    state_d  = S_END;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            S_END: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Pin-bus output decode from the next state, so the registered pins line
    // up with the state they belong to.
    // -----------------------------------------------------------------------
    always_comb begin
        cw_io_d  = 16'h0000;
        cw_req_d = 1'b0;
        cw_dir_d = 1'b0;

        unique case (state_d)
            S_HDR: begin
                cw_req_d = 1'b1;
                cw_io_d  = {we_d, bcode_d, sel_d, 3'b000, adr_d[23:16]};
            end
            S_ADR: begin
                cw_req_d = 1'b1;
                cw_io_d  = adr_d[15:0];
            end
            S_WDAT, S_WWAIT: begin
                cw_req_d = 1'b1;
                cw_io_d  = wdat_d;
            end
            S_TURN, S_RWAIT: begin
                cw_req_d = 1'b1;
                cw_dir_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            ack_r_q    <= 1'b0;
            err_r_q    <= 1'b0;
            dat_r_q    <= 16'h0000;
            we_q       <= 1'b0;
            sel_q      <= 2'b00;
            adr_q      <= 24'h000000;
            wdat_q     <= 16'h0000;
            bcode_q    <= 2'b00;
            beats_q    <= 4'd0;
            beat_q     <= 4'd0;
            tmo_q      <= '0;
            pend_q     <= 1'b0;
            cw_io_q    <= 16'h0000;
            cw_req_q   <= 1'b0;
            cw_dir_q   <= 1'b0;
            wb_ack_q   <= 1'b0;
            wb_err_q   <= 1'b0;
            wb_i_dat_q <= 16'h0000;
        end else begin
            state_q    <= state_d;
            ack_r_q    <= cw_ack;
            err_r_q    <= cw_err;
            dat_r_q    <= cw_io_i;
            we_q       <= we_d;
            sel_q      <= sel_d;
            adr_q      <= adr_d;
            wdat_q     <= wdat_d;
            bcode_q    <= bcode_d;
            beats_q    <= beats_d;
            beat_q     <= beat_d;
            tmo_q      <= tmo_d;
            pend_q     <= pend_d;
            cw_io_q    <= cw_io_d;
            cw_req_q   <= cw_req_d;
            cw_dir_q   <= cw_dir_d;
            wb_ack_q   <= wb_ack_d;
            wb_err_q   <= wb_err_d;
            wb_i_dat_q <= wb_i_dat_d;
        end
    end

    assign cw_io_o  = cw_io_q;
    assign cw_req   = cw_req_q;
    assign cw_dir   = cw_dir_q;
    assign wb_ack   = wb_ack_q;
    assign wb_err   = wb_err_q;
    assign wb_i_dat = wb_i_dat_q;

endmodule
